// File: rtl/dcm_ctrl.sv
// rtl/dcm_ctrl.sv - DCM reset/lock sequencer with stepped variable phase shift control
module dcm_ctrl #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 16,
  parameter int PS_WIDTH      = 8,
  parameter int PS_MAX        = 100,
  parameter int PS_TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dcm_locked,
  input  logic                dcm_psdone,
  input  logic [PS_WIDTH-1:0] ps_target,
  input  logic                ps_load,
  output logic                dcm_rst,
  output logic                dcm_psen,
  output logic                dcm_psincdec,
  output logic [PS_WIDTH-1:0] ps_current,
  output logic                ready,
  output logic                busy,
  output logic [7:0]          retry_count,
  output logic                fault
);

  localparam int T1   = (LOCK_TIMEOUT > PS_TIMEOUT) ? LOCK_TIMEOUT : PS_TIMEOUT;
  localparam int TMAX = (T1 > RST_CYCLES) ? T1 : RST_CYCLES;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam logic signed [PS_WIDTH-1:0] PMAX = PS_WIDTH'(PS_MAX);
  localparam logic signed [PS_WIDTH-1:0] NMAX = PS_WIDTH'(-PS_MAX);

  typedef enum logic [2:0] {RST_ASSERT, WAIT_LOCK, IDLE, PS_ISSUE, PS_WAIT} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  sync_q;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [SW-1:0]               stable_q, stable_d;
  logic signed [PS_WIDTH-1:0]  target_q, target_d;
  logic signed [PS_WIDTH-1:0]  cur_q, cur_d;
  logic signed [PS_WIDTH-1:0]  tgt_in, tgt_clamped;
  logic                        incdec_q, incdec_d;
  logic [7:0]                  retry_q, retry_d;
  logic                        fault_q, fault_d;
  logic                        locked_s, step_up, err;

  assign locked_s = sync_q[1];
  assign step_up  = target_q > cur_q;

  always_comb begin
    tgt_in = $signed(ps_target);
    if (tgt_in > PMAX)      tgt_clamped = PMAX;
    else if (tgt_in < NMAX) tgt_clamped = NMAX;
    else                    tgt_clamped = tgt_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= RST_ASSERT;
      cnt_q    <= '0;
      stable_q <= '0;
      target_q <= '0;
      cur_q    <= '0;
      incdec_q <= 1'b0;
      retry_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], dcm_locked};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      incdec_q <= incdec_d;
      retry_q  <= retry_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    stable_d = stable_q;
    target_d = target_q;
    cur_d    = cur_q;
    incdec_d = incdec_q;
    retry_d  = retry_q;
    fault_d  = 1'b0;
    err      = 1'b0;

    if (ps_load && state_q != RST_ASSERT) target_d = tgt_clamped;

    case (state_q)
      RST_ASSERT: begin
        target_d = '0;
        cur_d    = '0;
        stable_d = '0;
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        stable_d = locked_s ? stable_q + SW'(1) : '0;
        if (locked_s && stable_q == SW'(STABLE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          err = 1'b1;
        end
      end
      IDLE: begin
        if (!locked_s) err = 1'b1;
        else if (target_q != cur_q) begin
          state_d = PS_ISSUE;
          cnt_d   = '0;
        end
      end
      PS_ISSUE: begin
        incdec_d = step_up;
        if (!locked_s) err = 1'b1;
        else begin
          state_d = PS_WAIT;
          cnt_d   = '0;
        end
      end
      PS_WAIT: begin
        // Lock loss outranks PSDONE: the DCM reset discards the step anyway.
        if (!locked_s) err = 1'b1;
        else if (dcm_psdone) begin
          cur_d   = incdec_q ? cur_q + PS_WIDTH'(1) : cur_q - PS_WIDTH'(1);
          state_d = IDLE;
        end else if (cnt_q == CW'(PS_TIMEOUT - 1)) begin
          err = 1'b1;
        end
      end
      default: state_d = RST_ASSERT;
    endcase

    if (err) begin
      state_d  = RST_ASSERT;
      cnt_d    = '0;
      target_d = '0;
      cur_d    = '0;
      fault_d  = 1'b1;
      retry_d  = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    end
  end

  assign dcm_rst      = (state_q == RST_ASSERT);
  assign dcm_psen     = (state_q == PS_ISSUE);
  assign dcm_psincdec = (state_q == PS_ISSUE) ? step_up : incdec_q;
  assign ps_current   = cur_q;
  assign ready        = (state_q == IDLE) || (state_q == PS_ISSUE) || (state_q == PS_WAIT);
  assign busy         = (state_q == PS_ISSUE) || (state_q == PS_WAIT) ||
                        ((state_q == IDLE) && (target_q != cur_q));
  assign retry_count  = retry_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_dcm_ctrl.sv
// tb/tb_dcm_ctrl.sv - randomized self-checking bench for dcm_ctrl
module tb_dcm_ctrl;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dcm_locked = 1'b0;
  logic          dcm_psdone = 1'b0;
  logic [PW-1:0] ps_target = '0;
  logic          ps_load = 1'b0;
  logic          dcm_rst, dcm_psen, dcm_psincdec, ready, busy, fault;
  logic [PW-1:0] ps_current;
  logic [7:0]    retry_count;

  int vectors = 0;
  int errors  = 0;
  int up_cnt = 0, dn_cnt = 0, bad_psen = 0;
  int resp_delay = 4;
  bit resp_en = 1'b1;
  int pend = 0;

  dcm_ctrl dut (
    .clk(clk), .rst(rst), .dcm_locked(dcm_locked), .dcm_psdone(dcm_psdone),
    .ps_target(ps_target), .ps_load(ps_load), .dcm_rst(dcm_rst), .dcm_psen(dcm_psen),
    .dcm_psincdec(dcm_psincdec), .ps_current(ps_current), .ready(ready), .busy(busy),
    .retry_count(retry_count), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dcm_psen) begin
      if (dcm_psincdec) up_cnt++;
      else dn_cnt++;
      if (dcm_rst || !ready) bad_psen++;
    end
  end

  // PSDONE responder: pulses resp_delay cycles after each PSEN
  initial forever begin
    @(negedge clk);
    dcm_psdone = 1'b0;
    if (dcm_rst) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) dcm_psdone = 1'b1;
    end
    if (dcm_psen && resp_en && !dcm_rst) pend = resp_delay;
  end

  function automatic int clamp(int t);
    return (t > 100) ? 100 : ((t < -100) ? -100 : t);
  endfunction

  function automatic int cur();
    return int'($signed(ps_current));
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(int t);
    ps_target = t[PW-1:0];
    ps_load = 1'b1;
    tick(1);
    ps_load = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_ready(int bound);
    int n = 0;
    while (!ready && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick(4);
    vectors++; if (dcm_rst !== 1'b1) begin errors++; $display("FAIL reset_dcm_rst got %b exp 1", dcm_rst); end
    vectors++; if ({dcm_psen, ready, busy, fault} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {dcm_psen, ready, busy, fault}); end
    vectors++; if (ps_current !== '0 || retry_count !== '0) begin errors++; $display("FAIL reset_counts cur %0d retry %0d exp 0 0", ps_current, retry_count); end
    rst = 1'b0;
    n = 0;
    while (dcm_rst && n < 50) begin tick(1); n++; end
    vectors++; if (n !== 8) begin errors++; $display("FAIL rst_pulse_len got %0d exp 8", n); end
    tick(12);
    dcm_locked = 1'b1;
    n = 0;
    while (!ready && n < 100) begin tick(1); n++; end
    vectors++; if (n !== 18) begin errors++; $display("FAIL lock_to_ready got %0d exp 18", n); end
    vectors++; if (retry_count !== 8'd0 || dcm_rst !== 1'b0) begin errors++; $display("FAIL first_lock retry %0d dcm_rst %b exp 0 0", retry_count, dcm_rst); end
  endtask

  task automatic test_step_plus5();
    int u0, d0, prev, n;
    resp_delay = 4;
    u0 = up_cnt; d0 = dn_cnt;
    load(5);
    for (int i = 1; i <= 5; i++) begin
      prev = cur();
      n = 0;
      while (cur() == prev && n < 40) begin tick(1); n++; end
      vectors++; if (cur() !== i) begin errors++; $display("FAIL plus5_step got %0d exp %0d", cur(), i); end
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL plus5_ready got %b exp 1", ready); end
    end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL plus5_busy_drop got %b exp 0", busy); end
    vectors++; if (up_cnt - u0 !== 5 || dn_cnt - d0 !== 0) begin errors++; $display("FAIL plus5_pulses up %0d dn %0d exp 5 0", up_cnt - u0, dn_cnt - d0); end
  endtask

  task automatic test_clamp_flip();
    int u0, d0, n;
    load(0);
    wait_idle(100);
    u0 = up_cnt; d0 = dn_cnt;
    load(-120);
    n = 0;
    while (dn_cnt - d0 < 10 && n < 500) begin tick(1); n++; end
    vectors++; if (cur() !== -9) begin errors++; $display("FAIL flip_midrun_cur got %0d exp -9", cur()); end
    load(0);
    wait_idle(300);
    vectors++; if (cur() !== 0) begin errors++; $display("FAIL flip_final got %0d exp 0", cur()); end
    vectors++; if (dn_cnt - d0 !== 10 || up_cnt - u0 !== 10) begin errors++; $display("FAIL flip_pulses dn %0d up %0d exp 10 10", dn_cnt - d0, up_cnt - u0); end
    u0 = up_cnt; d0 = dn_cnt;
    load(-120);
    wait_idle(1200);
    vectors++; if (cur() !== -100) begin errors++; $display("FAIL clamp_final got %0d exp -100", cur()); end
    vectors++; if (dn_cnt - d0 !== 100 || up_cnt - u0 !== 0) begin errors++; $display("FAIL clamp_pulses dn %0d up %0d exp 100 0", dn_cnt - d0, up_cnt - u0); end
  endtask

  task automatic test_random_phase();
    int t, e, c0, u0, d0, r0;
    for (int it = 0; it < 8; it++) begin
      t = int'($urandom_range(0, 255)) - 128;
      resp_delay = int'($urandom_range(1, 6));
      e = clamp(t);
      c0 = cur(); u0 = up_cnt; d0 = dn_cnt; r0 = int'(retry_count);
      load(t);
      wait_idle(((e > c0) ? e - c0 : c0 - e) * 12 + 20);
      vectors++; if (cur() !== e || busy !== 1'b0) begin errors++; $display("FAIL rand_final tgt %0d got %0d busy %b exp %0d", t, cur(), busy, e); end
      vectors++; if (up_cnt - u0 !== ((e > c0) ? e - c0 : 0) || dn_cnt - d0 !== ((c0 > e) ? c0 - e : 0)) begin
        errors++; $display("FAIL rand_pulses up %0d dn %0d from %0d to %0d", up_cnt - u0, dn_cnt - d0, c0, e);
      end
      vectors++; if (ready !== 1'b1 || int'(retry_count) !== r0) begin errors++; $display("FAIL rand_stable ready %b retry %0d exp 1 %0d", ready, retry_count, r0); end
    end
  endtask

  task automatic test_equal_load();
    int u0, d0, c;
    c = cur(); u0 = up_cnt; d0 = dn_cnt;
    load(c);
    tick(10);
    vectors++; if (up_cnt - u0 + dn_cnt - d0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL equal_load pulses %0d busy %b exp 0 0", up_cnt - u0 + dn_cnt - d0, busy); end
  endtask

  task automatic test_lock_loss();
    int u0, n, r0;
    resp_delay = 4;
    load(0);
    wait_idle(1500);
    u0 = up_cnt; r0 = int'(retry_count);
    load(10);
    n = 0;
    while (up_cnt - u0 < 4 && n < 200) begin tick(1); n++; end
    vectors++; if (cur() !== 3) begin errors++; $display("FAIL lossprep_cur got %0d exp 3", cur()); end
    dcm_locked = 1'b0;
    n = 0;
    while (ready && n < 10) begin tick(1); n++; end
    vectors++; if (n > 3 || ready !== 1'b0) begin errors++; $display("FAIL loss_ready_drop got %0d cycles exp <=3", n); end
    vectors++; if (fault !== 1'b1 || dcm_rst !== 1'b1) begin errors++; $display("FAIL loss_fault fault %b dcm_rst %b exp 1 1", fault, dcm_rst); end
    vectors++; if (cur() !== 0 || int'(retry_count) !== r0 + 1) begin errors++; $display("FAIL loss_state cur %0d retry %0d exp 0 %0d", cur(), retry_count, r0 + 1); end
    tick(1);
    vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL loss_fault_pulse got %b exp 0", fault); end
    u0 = up_cnt + dn_cnt;
    tick(50);
    vectors++; if (up_cnt + dn_cnt !== u0) begin errors++; $display("FAIL loss_no_psen got %0d extra exp 0", up_cnt + dn_cnt - u0); end
    dcm_locked = 1'b1;
    wait_ready(200);
    tick(5);
    vectors++; if (ready !== 1'b1 || cur() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL relock ready %b cur %0d busy %b exp 1 0 0", ready, cur(), busy); end
  endtask

  task automatic test_ps_timeout();
    int u0, n, r0;
    resp_en = 1'b0;
    u0 = up_cnt; r0 = int'(retry_count);
    load(1);
    n = 0;
    while (up_cnt - u0 < 1 && n < 20) begin tick(1); n++; end
    n = 0;
    while (!fault && n < 400) begin tick(1); n++; end
    vectors++; if (n !== 255) begin errors++; $display("FAIL ps_timeout_len got %0d exp 255", n); end
    vectors++; if (dcm_rst !== 1'b1 || ready !== 1'b0 || int'(retry_count) !== r0 + 1) begin
      errors++; $display("FAIL ps_timeout_state dcm_rst %b ready %b retry %0d exp 1 0 %0d", dcm_rst, ready, retry_count, r0 + 1);
    end
    resp_en = 1'b1;
    wait_ready(200);
    vectors++; if (ready !== 1'b1 || cur() !== 0) begin errors++; $display("FAIL ps_timeout_recover ready %b cur %0d exp 1 0", ready, cur()); end
  endtask

  task automatic test_lock_timeout();
    int n;
    rst = 1'b1;
    dcm_locked = 1'b0;
    tick(1);
    vectors++; if (dcm_rst !== 1'b1 || ready !== 1'b0 || retry_count !== 8'd0 || ps_current !== '0) begin
      errors++; $display("FAIL midop_rst dcm_rst %b ready %b retry %0d cur %0d exp 1 0 0 0", dcm_rst, ready, retry_count, ps_current);
    end
    tick(3);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (dcm_rst && n < 20) begin tick(1); n++; end
      vectors++; if (n !== 8) begin errors++; $display("FAIL retry_rst_len got %0d exp 8", n); end
      n = 0;
      while (!dcm_rst && n < 5000) begin tick(1); n++; end
      vectors++; if (n !== 4096 || fault !== 1'b1) begin errors++; $display("FAIL lock_timeout got %0d fault %b exp 4096 1", n, fault); end
      vectors++; if (int'(retry_count) !== k) begin errors++; $display("FAIL retry_count got %0d exp %0d", retry_count, k); end
    end
    dcm_locked = 1'b1;
    wait_ready(6000);
    vectors++; if (ready !== 1'b1 || retry_count !== 8'd3) begin errors++; $display("FAIL late_lock ready %b retry %0d exp 1 3", ready, retry_count); end
  endtask

  task automatic test_invariants();
    vectors++; if (bad_psen !== 0) begin errors++; $display("FAIL psen_guard got %0d bad pulses exp 0", bad_psen); end
  endtask

  initial begin
    #1;
    test_reset();
    test_step_plus5();
    test_clamp_flip();
    test_random_phase();
    test_equal_load();
    test_lock_loss();
    test_ps_timeout();
    test_lock_timeout();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
